// File: rtl/wave_display.sv
// rtl/wave_display.sv - DSO display-side line buffer snapshot and waveform trace renderer
//
// Purpose: at each frame_start, copies HORIZONTAL samples from the capture
// stage into a private line buffer and pulses ram_rd_over when done. During
// active video it draws the buffered samples as a vertically connected trace
// inside a 256-row window, over the background and an optional grid. Pixel
// outputs follow the pix_* inputs by exactly two clocks.
//
// Optional feature: define WAVE_GRID_EN to draw the dotted grid and the
// window border rows. When it is not defined, no grid logic is built.
//
// Ports:
//   ram_rd_clk    in   1   pixel clock, all logic
//   rstn          in   1   asynchronous active-low reset
//   frame_start   in   1   one-cycle pulse at start of vertical blanking
//   pix_de        in   1   active-video qualifier
//   pix_x         in  11   current pixel column
//   pix_y         in  11   current pixel row
//   ram_rd_en     out  1   high while issuing snapshot reads
//   wave_rd_addr  out 10   sample address to capture stage
//   wave_rd_data  in   8   sample, valid one cycle after address (255 = out of range)
//   ram_rd_over   out  1   one-cycle pulse, snapshot complete
//   out_de        out  1   pix_de delayed two cycles
//   out_rgb       out 24   pixel colour aligned to out_de

module wave_display #(
    parameter int          HORIZONTAL  = 640,
    parameter int          X_START     = 0,
    parameter int          Y_START     = 112,
    parameter logic [23:0] TRACE_COLOR = 24'hFFFF00,
    parameter logic [23:0] GRID_COLOR  = 24'h404040,
    parameter logic [23:0] BG_COLOR    = 24'h000000
) (
    input  logic        ram_rd_clk,
    input  logic        rstn,
    input  logic        frame_start,
    input  logic        pix_de,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    output logic        ram_rd_en,
    output logic [9:0]  wave_rd_addr,
    input  logic [7:0]  wave_rd_data,
    output logic        ram_rd_over,
    output logic        out_de,
    output logic [23:0] out_rgb
);

    localparam logic [10:0] X_LO      = 11'(X_START);
    localparam logic [10:0] X_HI      = 11'(X_START + HORIZONTAL);
    localparam logic [10:0] Y_LO      = 11'(Y_START);
    localparam logic [10:0] Y_HI      = 11'(Y_START + 256);
    localparam logic [9:0]  LAST_ADDR = 10'(HORIZONTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t state;
    logic   buf_valid;

    // Snapshot sequencer. frame_start is only honoured in IDLE.
    always_ff @(posedge ram_rd_clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            ram_rd_en    <= 1'b0;
            wave_rd_addr <= 10'd0;
            ram_rd_over  <= 1'b0;
            buf_valid    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ram_rd_over <= 1'b0;
                    if (frame_start) begin
                        state        <= S_LOAD;
                        ram_rd_en    <= 1'b1;
                        wave_rd_addr <= 10'd0;
                    end
                end
                S_LOAD: begin
                    if (wave_rd_addr == LAST_ADDR) begin
                        state       <= S_DONE;
                        ram_rd_en   <= 1'b0;
                        ram_rd_over <= 1'b1;
                    end else begin
                        wave_rd_addr <= wave_rd_addr + 10'd1;
                    end
                end
                S_DONE: begin
                    ram_rd_over <= 1'b0;
                    buf_valid   <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    ram_rd_en <= 1'b0;
                end
            endcase
        end
    end

    // Read data arrives one cycle after its address, so the write side uses
    // the address/enable delayed by one clock. The last sample lands in DONE.
    logic       wr_en_q;
    logic [9:0] wr_addr_q;

    always_ff @(posedge ram_rd_clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= 10'd0;
        end else begin
            wr_en_q   <= ram_rd_en;
            wr_addr_q <= wave_rd_addr;
        end
    end

    logic [7:0] line_buf [0:HORIZONTAL-1];

    always_ff @(posedge ram_rd_clk) begin
        if (wr_en_q) begin
            line_buf[wr_addr_q] <= wave_rd_data;
        end
    end

    // Stage 1: window decode and registered buffer read.
    logic       col_in;
    logic       row_in;
    logic [9:0] col_idx;
    logic [7:0] row_idx;

    assign col_in  = (pix_x >= X_LO) && (pix_x < X_HI);
    assign row_in  = (pix_y >= Y_LO) && (pix_y < Y_HI);
    assign col_idx = 10'(pix_x - X_LO);
    assign row_idx = 8'(pix_y - Y_LO);

    logic [7:0] cur_q;
    logic [7:0] prev_q;

    // Outside the window the read is held, so prev_q always tracks the
    // previous in-window column.
    always_ff @(posedge ram_rd_clk) begin
        if (col_in) begin
            cur_q  <= line_buf[col_idx];
            prev_q <= cur_q;
        end
    end

    logic       de1;
    logic       win1;
    logic       first1;
    logic [7:0] row1;
`ifdef WAVE_GRID_EN
    logic [9:0] col1;
`endif

    always_ff @(posedge ram_rd_clk or negedge rstn) begin
        if (!rstn) begin
            de1    <= 1'b0;
            win1   <= 1'b0;
            first1 <= 1'b0;
            row1   <= 8'd0;
`ifdef WAVE_GRID_EN
            col1   <= 10'd0;
`endif
        end else begin
            de1    <= pix_de;
            win1   <= col_in && row_in;
            first1 <= (pix_x == X_LO);
            row1   <= row_idx;
`ifdef WAVE_GRID_EN
            col1   <= col_idx;
`endif
        end
    end

    // Stage 2: trace/grid decision. Levels are inverted samples (255 - d).
    logic [7:0] prev_eff;
    logic [7:0] lvl_cur;
    logic [7:0] lvl_prev;
    logic [7:0] lvl_lo;
    logic [7:0] lvl_hi;
    logic       trace_hit;
    logic       grid_hit;

    always_comb begin
        // An out-of-range previous sample (or the first column) collapses the
        // segment to the current sample alone.
        prev_eff  = (first1 || (prev_q == 8'hFF)) ? cur_q : prev_q;
        lvl_cur   = ~cur_q;
        lvl_prev  = ~prev_eff;
        lvl_lo    = (lvl_cur < lvl_prev) ? lvl_cur : lvl_prev;
        lvl_hi    = (lvl_cur < lvl_prev) ? lvl_prev : lvl_cur;
        trace_hit = win1 && buf_valid && (cur_q != 8'hFF)
                    && (row1 >= lvl_lo) && (row1 <= lvl_hi);
`ifdef WAVE_GRID_EN
        // Vertical lines every 64 columns dotted every 4th row, horizontal
        // lines every 32 rows dotted every 4th column, solid border rows.
        grid_hit  = win1 && (((col1[5:0] == 6'd0) && (row1[1:0] == 2'd0))
                          || ((row1[4:0] == 5'd0) && (col1[1:0] == 2'd0))
                          || (row1 == 8'd0) || (row1 == 8'd255));
`else
        grid_hit  = 1'b0;
`endif
    end

    always_ff @(posedge ram_rd_clk or negedge rstn) begin
        if (!rstn) begin
            out_de  <= 1'b0;
            out_rgb <= 24'd0;
        end else begin
            out_de <= de1;
            if (!de1) begin
                out_rgb <= 24'd0;
            end else if (trace_hit) begin
                out_rgb <= TRACE_COLOR;
            end else if (grid_hit) begin
                out_rgb <= GRID_COLOR;
            end else begin
                out_rgb <= BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_wave_display.sv
// tb/tb_wave_display.sv - directed table-driven bench for wave_display
module tb_wave_display;

    localparam logic [23:0] TRACE = 24'hFFFF00;
    localparam logic [23:0] GRID  = 24'h404040;
    localparam logic [23:0] BG    = 24'h000000;
    localparam int          YS    = 112;
`ifdef WAVE_GRID_EN
    localparam logic [23:0] GRID_EXP = GRID;
`else
    localparam logic [23:0] GRID_EXP = BG;
`endif

    logic        ram_rd_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_de = 1'b0;
    logic [10:0] pix_x = 11'd0;
    logic [10:0] pix_y = 11'd0;
    logic        ram_rd_en;
    logic [9:0]  wave_rd_addr;
    logic [7:0]  wave_rd_data = 8'd0;
    logic        ram_rd_over;
    logic        out_de;
    logic [23:0] out_rgb;

    wave_display dut (
        .ram_rd_clk   (ram_rd_clk),
        .rstn         (rstn),
        .frame_start  (frame_start),
        .pix_de       (pix_de),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .ram_rd_en    (ram_rd_en),
        .wave_rd_addr (wave_rd_addr),
        .wave_rd_data (wave_rd_data),
        .ram_rd_over  (ram_rd_over),
        .out_de       (out_de),
        .out_rgb      (out_rgb)
    );

    always #5 ram_rd_clk = ~ram_rd_clk;

    // Capture-stage sample RAM: data valid one cycle after the address.
    logic [7:0] cap_mem [0:1023];
    always @(posedge ram_rd_clk) wave_rd_data <= cap_mem[wave_rd_addr];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          x;
        int          y;
        bit          de;
        logic [23:0] rgb;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int x, input int y, input bit de, input logic [23:0] rgb,
                           input string name);
        vec_t v;
        v.x = x; v.y = y; v.de = de; v.rgb = rgb; v.name = name;
        tbl.push_back(v);
    endtask

    // Drives the previous column then the target column on the same row, so
    // the segment start comes from the real neighbour, and checks the target
    // pixel two clocks after it was presented.
    task automatic apply_vec(input vec_t v);
        int px;
        px = (v.x > 0) ? v.x - 1 : v.x;
        @(negedge ram_rd_clk);
        pix_x = 11'(px); pix_y = 11'(v.y); pix_de = v.de;
        @(negedge ram_rd_clk);
        pix_x = 11'(v.x);
        @(negedge ram_rd_clk);
        pix_de = 1'b0;
        @(negedge ram_rd_clk);
        check({v.name, "_de"}, 32'(out_de), 32'(v.de));
        check({v.name, "_rgb"}, 32'(out_rgb), 32'(v.rgb));
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply_vec(tbl[i]);
        tbl.delete();
    endtask

    // frame_start at cycle 0; observes cycles 1..700. A second frame_start is
    // injected at cycle 100 (inside LOAD). abort_cycle>0 pulses rstn there.
    task automatic run_snapshot(input string tag, input int abort_cycle);
        int en_cnt, over_cnt, addr_err, over_at;
        en_cnt = 0; over_cnt = 0; addr_err = 0; over_at = -1;
        @(negedge ram_rd_clk);
        frame_start = 1'b1;
        @(negedge ram_rd_clk);
        frame_start = 1'b0;
        for (int i = 1; i <= 700; i++) begin
            if (i > 1) @(negedge ram_rd_clk);
            if (ram_rd_en) begin
                en_cnt++;
                if (wave_rd_addr != 10'(i - 1)) addr_err++;
            end
            if (ram_rd_over) begin
                over_cnt++;
                over_at = i;
            end
            if (i == 100) frame_start = 1'b1;
            if (i == 101) frame_start = 1'b0;
            if (abort_cycle > 0 && i == abort_cycle) rstn = 1'b0;
            if (abort_cycle > 0 && i == abort_cycle + 3) rstn = 1'b1;
        end
        if (abort_cycle > 0) begin
            check({tag, "_en_cycles"}, 32'(en_cnt), 32'(abort_cycle));
            check({tag, "_no_over"}, 32'(over_cnt), 32'd0);
        end else begin
            check({tag, "_en_cycles"}, 32'(en_cnt), 32'd640);
            check({tag, "_over_count"}, 32'(over_cnt), 32'd1);
            check({tag, "_over_cycle"}, 32'(over_at), 32'd641);
        end
        check({tag, "_addr_seq"}, 32'(addr_err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) cap_mem[i] = 8'd128;

        rstn = 1'b0;
        repeat (3) @(negedge ram_rd_clk);
        check("rst_rd_en", 32'(ram_rd_en), 32'd0);
        check("rst_addr", 32'(wave_rd_addr), 32'd0);
        check("rst_over", 32'(ram_rd_over), 32'd0);
        check("rst_out_de", 32'(out_de), 32'd0);
        check("rst_out_rgb", 32'(out_rgb), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge ram_rd_clk);
        check("idle_rd_en", 32'(ram_rd_en), 32'd0);

        // No snapshot yet: trace suppressed.
        add_vec(5, YS + 127, 1'b1, BG, "pre_snap");
        run_table();

        // Reset mid-LOAD: no completion, trace still suppressed.
        run_snapshot("abort", 300);
        add_vec(5, YS + 127, 1'b1, BG, "abort_no_trace");
        run_table();

        // Flat 128 capture.
        run_snapshot("snap1", 0);

        // Latency: exactly two cycles.
        @(negedge ram_rd_clk);
        pix_x = 11'd0; pix_y = 11'(YS + 127); pix_de = 1'b1;
        @(negedge ram_rd_clk);
        check("lat_t1_de", 32'(out_de), 32'd0);
        pix_x = 11'd1;
        @(negedge ram_rd_clk);
        check("lat_t2_de", 32'(out_de), 32'd1);
        check("lat_t2_rgb", 32'(out_rgb), 32'(TRACE));
        pix_de = 1'b0;
        repeat (2) @(negedge ram_rd_clk);

        add_vec(0,   YS + 127, 1'b1, TRACE,    "flat_c0");
        add_vec(1,   YS + 127, 1'b1, TRACE,    "flat_c1");
        add_vec(320, YS + 127, 1'b1, TRACE,    "flat_c320");
        add_vec(639, YS + 127, 1'b1, TRACE,    "flat_c639");
        add_vec(321, YS + 126, 1'b1, BG,       "flat_r126");
        add_vec(321, YS + 128, 1'b1, BG,       "flat_r128");
        add_vec(321, YS + 0,   1'b1, GRID_EXP, "flat_border0");
        add_vec(320, YS + 127, 1'b0, 24'd0,    "flat_no_de");
        add_vec(640, YS + 127, 1'b1, BG,       "out_col640");
        add_vec(321, YS + 256, 1'b1, BG,       "out_row256");
        add_vec(321, YS - 1,   1'b1, BG,       "out_row_m1");
        add_vec(64,  YS + 32,  1'b1, GRID_EXP, "grid_64_32");
        add_vec(65,  YS + 33,  1'b1, BG,       "grid_65_33");
        run_table();

        // Shaped capture.
        cap_mem[10]  = 8'd0;
        cap_mem[11]  = 8'd255;
        cap_mem[12]  = 8'd200;
        cap_mem[99]  = 8'd50;
        cap_mem[100] = 8'd150;
        run_snapshot("snap2", 0);

        add_vec(10,  YS + 255, 1'b1, TRACE,    "c10_r255");
        add_vec(10,  YS + 127, 1'b1, TRACE,    "c10_r127");
        add_vec(10,  YS + 200, 1'b1, TRACE,    "c10_r200");
        add_vec(10,  YS + 126, 1'b1, BG,       "c10_r126");
        add_vec(11,  YS + 127, 1'b1, BG,       "c11_r127");
        add_vec(11,  YS + 255, 1'b1, GRID_EXP, "c11_r255");
        add_vec(12,  YS + 55,  1'b1, TRACE,    "c12_r55");
        add_vec(12,  YS + 54,  1'b1, BG,       "c12_r54");
        add_vec(12,  YS + 56,  1'b1, BG,       "c12_r56");
        add_vec(100, YS + 105, 1'b1, TRACE,    "c100_r105");
        add_vec(100, YS + 150, 1'b1, TRACE,    "c100_r150");
        add_vec(100, YS + 205, 1'b1, TRACE,    "c100_r205");
        add_vec(100, YS + 104, 1'b1, BG,       "c100_r104");
        add_vec(100, YS + 206, 1'b1, BG,       "c100_r206");
        run_table();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
